// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if: serial input and recovered parallel outputs of the deserializer
interface serial_paralelo_if;
    logic       in_serial;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    modport master (output in_serial, input data_out, valid_out, active);
    modport slave  (input in_serial, output data_out, valid_out, active);
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo: MSB-first deserializer that aligns on COM bytes and outputs non-COM bytes once active
module serial_paralelo #(
    parameter logic [7:0] COM          = 8'hBC,
    parameter int         ACTIVE_COUNT = 4
) (
    input logic              clk_32f,
    input logic              reset,
    serial_paralelo_if.slave bus
);
    localparam int CW = ($clog2(ACTIVE_COUNT + 1) > 3) ? $clog2(ACTIVE_COUNT + 1) : 3;
    localparam logic [CW-1:0] CMAX = CW'(ACTIVE_COUNT);
    localparam logic [1:0] SEARCH = 2'd0, ALIGN = 2'd1, ACTIVE = 2'd2;
    logic [1:0]    state, state_nxt;
    logic [7:0]    shift, cand;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] com_cnt, com_nxt, com_inc;
    logic          boundary, is_com;
    assign cand     = {shift[6:0], bus.in_serial};
    assign boundary = bit_cnt == 3'd7;
    assign is_com   = cand == COM;
    assign com_inc  = com_cnt + 1'b1;
    always_comb begin
        state_nxt = state;
        com_nxt   = com_cnt;
        if (state == SEARCH && is_com) begin
            com_nxt   = 1;
            state_nxt = (CMAX <= 1) ? ACTIVE : ALIGN;
        end else if (state == ALIGN && boundary) begin
            com_nxt   = is_com ? ((com_inc >= CMAX) ? CMAX : com_inc) : '0;
            state_nxt = !is_com ? SEARCH : (com_inc >= CMAX) ? ACTIVE : ALIGN;
        end
    end
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state         <= SEARCH;
            shift         <= '0;
            bit_cnt       <= '0;
            com_cnt       <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.active    <= 1'b0;
        end else begin
            state      <= state_nxt;
            com_cnt    <= com_nxt;
            shift      <= cand;
            bus.active <= state_nxt == ACTIVE;
            // a SEARCH hit defines the byte grid: the next sampled bit is bit 7
            bit_cnt    <= (state == SEARCH && is_com) ? 3'd0 : bit_cnt + 3'd1;
            if (state == ACTIVE && boundary) begin
                bus.valid_out <= !is_com;
                if (!is_com) bus.data_out <= cand;
            end
        end
    end
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: directed bench for the COM-aligned deserializer
module tb_serial_paralelo;
    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    logic [7:0] cur_d = 8'h00;
    logic       cur_v = 1'b0;
    serial_paralelo_if bus ();
    serial_paralelo #(.COM(8'hBC), .ACTIVE_COUNT(4)) dut (.clk_32f(clk_32f), .reset(reset), .bus(bus));
    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.in_serial = b;
        @(posedge clk_32f);
        #1;
    endtask

    // sends a byte; outputs must hold during bits 7..1 and take ed/ev on the boundary edge
    task automatic send_chk(input logic [7:0] b, input logic [7:0] ed, input logic ev);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i > 0) begin
                check("hold_data", bus.data_out, cur_d);
                check("hold_valid", {7'd0, bus.valid_out}, {7'd0, cur_v});
            end
        end
        check("byte_data", bus.data_out, ed);
        check("byte_valid", {7'd0, bus.valid_out}, {7'd0, ev});
        cur_d = ed;
        cur_v = ev;
    endtask

    task automatic reset_pulse();
        @(negedge clk_32f);
        reset = 1'b0;
        #1;
        check("rst_data", bus.data_out, 8'h00);
        check("rst_valid", {7'd0, bus.valid_out}, 8'h00);
        check("rst_active", {7'd0, bus.active}, 8'h00);
        repeat (3) @(negedge clk_32f);
        reset = 1'b1;
        cur_d = 8'h00;
        cur_v = 1'b0;
    endtask

    // four aligned COMs: active must stay low until the last bit of the fourth
    task automatic link_up();
        for (int k = 0; k < 3; k++) begin
            send_chk(8'hBC, cur_d, 1'b0);
            check("pre_active", {7'd0, bus.active}, 8'h00);
        end
        for (int i = 7; i >= 1; i--) send_bit(bit'(8'hBC >> i));
        check("active_early", {7'd0, bus.active}, 8'h00);
        send_bit(1'b0);
        check("active_rise", {7'd0, bus.active}, 8'h01);
        check("active_valid", {7'd0, bus.valid_out}, 8'h00);
    endtask

    logic [7:0] up_b [8] = '{8'h12, 8'h00, 8'h34, 8'h00, 8'hA5, 8'h7E, 8'h00, 8'hC3};
    logic       up_v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        bus.in_serial = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("init_data", bus.data_out, 8'h00);
        check("init_valid", {7'd0, bus.valid_out}, 8'h00);
        check("init_active", {7'd0, bus.active}, 8'h00);
        @(negedge clk_32f);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send_bit(1'b0);
            check("zero_data", bus.data_out, 8'h00);
            check("zero_valid", {7'd0, bus.valid_out}, 8'h00);
            check("zero_active", {7'd0, bus.active}, 8'h00);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        link_up();
        send_chk(8'h01, 8'h01, 1'b1);
        send_chk(8'hFF, 8'hFF, 1'b1);
        send_chk(8'hBC, 8'hFF, 1'b0);
        send_chk(8'h5A, 8'h5A, 1'b1);
        check("still_active", {7'd0, bus.active}, 8'h01);
        for (int i = 7; i >= 4; i--) send_bit(bit'(8'h33 >> i));
        reset_pulse();
        for (int k = 0; k < 3; k++) send_chk(8'hBC, 8'h00, 1'b0);
        send_chk(8'h00, 8'h00, 1'b0);
        check("search_again", {7'd0, bus.active}, 8'h00);
        link_up();
        // upstream serializer model: idle slots carry COM, valid slots carry the byte
        for (int k = 0; k < 8; k++)
            send_chk(up_v[k] ? up_b[k] : 8'hBC, up_v[k] ? up_b[k] : cur_d, up_v[k]);
        check("b2b_active", {7'd0, bus.active}, 8'h01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_paralelo.md
SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 Parameter COM, default 8'hBC, comma/idle symbol used for alignment and as the filler byte.
REQ-002 Parameter ACTIVE_COUNT, default 4, number of consecutive aligned COM bytes needed to declare the link active.
REQ-003 Port clk_32f, input, 1, serial bit clock; one bit sampled per rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port in_serial, input, 1, serial bitstream from the upstream paralelo_serial stage, MSB first.
REQ-006 Port data_out, output, 8, last recovered non-COM byte.
REQ-007 Port valid_out, output, 1, high while data_out holds a byte received in ACTIVE state.
REQ-008 Port active, output, 1, high once link alignment is established.

Function
REQ-009 All outputs SHALL be registered on the rising edge of clk_32f.
REQ-010 An 8-bit shift register SHALL shift in in_serial each edge, MSB first; the candidate byte at an edge is {shift[6:0], in_serial}.
REQ-011 A 3-bit bit counter SHALL mark byte boundaries; the boundary edge is the edge at which the 8th bit of a byte is sampled; the counter wraps 7 -> 0.
REQ-012 States SHALL be SEARCH, ALIGN and ACTIVE.
REQ-013 SEARCH: every edge the candidate byte is compared to COM; on match, bit counter restarts so the next sampled bit is bit 7 of a new byte, COM count = 1, next state ALIGN (or ACTIVE directly if ACTIVE_COUNT = 1).
REQ-014 ALIGN: comparison only at boundary edges; COM match increments COM count; when count reaches ACTIVE_COUNT, next state ACTIVE on that same edge.
REQ-015 ALIGN: non-COM byte at a boundary edge SHALL clear COM count and return to SEARCH; bit-by-bit search resumes on the following edge.
REQ-016 ACTIVE SHALL be held until reset; no loss-of-alignment exit.
REQ-017 active SHALL be 1 exactly when state is ACTIVE, i.e. it rises on the boundary edge of the ACTIVE_COUNT-th COM.
REQ-018 ACTIVE, boundary edge, byte != COM: data_out <= byte, valid_out <= 1.
REQ-019 ACTIVE, boundary edge, byte == COM: valid_out <= 0, data_out holds its prior value.
REQ-020 data_out and valid_out SHALL change only at boundary edges in ACTIVE state, so each value holds for 8 clk_32f cycles.
REQ-021 In SEARCH and ALIGN, valid_out SHALL be 0 and data_out SHALL hold.
REQ-022 The boundary edge on which active rises SHALL leave valid_out 0, because that byte is COM.
REQ-023 COM count SHALL saturate at ACTIVE_COUNT and SHALL be at least 3 bits wide.

Reset
REQ-024 With reset low, state = SEARCH, shift register = 0, bit counter = 0, COM count = 0, data_out = 8'h00, valid_out = 0 and active = 0, immediately and without waiting for a clock edge.
REQ-025 Reset asserted mid-byte or in ACTIVE SHALL discard all partial data; after release, alignment restarts from SEARCH.
REQ-026 The first edge after reset rises SHALL sample in_serial normally.

Verification
REQ-027 Reset release with in_serial constantly 0 for 64 cycles -> state SEARCH; data_out 0x00, valid_out 0 and active 0 throughout.
REQ-028 3 junk bits 101, then 4x 0xBC MSB first -> active rises on the edge sampling the last bit of the 4th 0xBC; valid_out stays 0.
REQ-029 After activation, send 0x01, 0xFF, 0xBC, 0x5A -> data_out/valid_out = 01/1, FF/1, FF/0, 5A/1, each held 8 cycles and updated at the boundary edges.
REQ-030 3x 0xBC then 0x00 then 4x 0xBC -> return to SEARCH after 0x00 with active still 0; active rises only at the end of the second 4-COM run.
REQ-031 Reset pulled low for 3 cycles at bit 4 of a data byte in ACTIVE -> all outputs 0 asynchronously; after release, 4x 0xBC is required again before active.
REQ-032 Back-to-back check with the upstream paralelo_serial on the same clk_32f, where valid_in = 0 sends COM -> every byte presented with valid_in = 1 after link-up appears on data_out with valid_out = 1, in order.
